// File: rtl/timer_sequencer.sv
// Sequencer for the timer path's saturating tick counter: clears it, ticks it, detects its Q flag.
// Latency: all outputs registered, decoded from next state; done rises 3 cycles after the Q-setting tick.
// Backpressure: none; pause freezes the prescaler and holds back a tick due in the pause cycle.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start/pause/cancel run control (priority cancel > Q detect > pause > start)
//   cnt_q              counter timeout flag, asynchronous to clock (2-flop synchronized)
//   cnt_reset/cnt_tick counter reset and one-cycle clock pulse
//   busy/paused/done   status levels; err = watchdog trip
// Build option: define WATCHDOG_EN to add the MAX_TICKS watchdog and the ERR state.
module timer_sequencer #(
    parameter int TICK_DIV  = 4,
    parameter int DIV_W     = 8,
    parameter int MAX_TICKS = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic pause,
    input  logic cancel,
    input  logic cnt_q,
    output logic cnt_reset,
    output logic cnt_tick,
    output logic busy,
    output logic paused,
    output logic done,
    output logic err
);

    if (TICK_DIV < 2 || (TICK_DIV - 1) >= (1 << DIV_W)) begin : g_bad_div
        $error("timer_sequencer: TICK_DIV must be >= 2 and TICK_DIV-1 must fit in DIV_W bits");
    end
    if (MAX_TICKS < 1 || MAX_TICKS > 15) begin : g_bad_max
        $error("timer_sequencer: MAX_TICKS must be in 1..15");
    end

`ifdef WATCHDOG_EN
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_PAUSE, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_PAUSE, S_DONE
    } state_t;
`endif

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] presc, presc_nxt;
    logic             clr_cnt, clr_cnt_nxt;   // set during the second CLEAR cycle
    logic             tick_nxt;
    logic             q_m, q_s;
    logic             presc_last;

    assign presc_last = (presc == DIV_LAST);

`ifdef WATCHDOG_EN
    logic [3:0] tick_cnt, tick_cnt_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        clr_cnt_nxt = 1'b0;
        tick_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cancel && start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (cancel)       state_nxt = S_IDLE;
                else if (clr_cnt) state_nxt = S_RUN;
                else              clr_cnt_nxt = 1'b1;
            end
            S_RUN: begin
                if (cancel)     state_nxt = S_IDLE;
                else if (q_s)   state_nxt = S_DONE;
`ifdef WATCHDOG_EN
                else if (tick_cnt >= 4'(MAX_TICKS)) state_nxt = S_ERR;
`endif
                // Pausing leaves presc untouched, so a tick due now is held back.
                else if (pause) state_nxt = S_PAUSE;
                else begin
                    tick_nxt  = presc_last;
                    presc_nxt = presc_last ? '0 : presc + DIV_W'(1);
                end
            end
            S_PAUSE: begin
                if (cancel)     state_nxt = S_IDLE;
                else if (pause) state_nxt = S_PAUSE;
                else if (start) begin
                    state_nxt = S_RUN;
                    // presc frozen at its last value means a tick was held back:
                    // issue it on the resume edge and restart the division.
                    if (presc_last) begin
                        tick_nxt  = 1'b1;
                        presc_nxt = '0;
                    end
                end
            end
            S_DONE: begin
                if (cancel)     state_nxt = S_IDLE;
                else if (start) state_nxt = S_CLEAR;
            end
`ifdef WATCHDOG_EN
            S_ERR: begin
                if (cancel) state_nxt = S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt == S_IDLE || state_nxt == S_CLEAR) presc_nxt = '0;
    end

`ifdef WATCHDOG_EN
    always_comb begin
        tick_cnt_nxt = tick_cnt;
        if (state_nxt == S_IDLE || state_nxt == S_CLEAR) tick_cnt_nxt = '0;
        else if (tick_nxt && tick_cnt != 4'd15)         tick_cnt_nxt = tick_cnt + 4'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) tick_cnt <= '0;
        else       tick_cnt <= tick_cnt_nxt;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            presc   <= '0;
            clr_cnt <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Synchronizer is flushed during CLEAR so a Q left over from the
    // previous run cannot reach RUN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_m <= 1'b0;
            q_s <= 1'b0;
        end else if (state == S_CLEAR) begin
            q_m <= 1'b0;
            q_s <= 1'b0;
        end else begin
            q_m <= cnt_q;
            q_s <= q_m;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reset <= 1'b1;
            cnt_tick  <= 1'b0;
            busy      <= 1'b0;
            paused    <= 1'b0;
            done      <= 1'b0;
        end else begin
            cnt_reset <= (state_nxt == S_IDLE) || (state_nxt == S_CLEAR);
            cnt_tick  <= tick_nxt;
            busy      <= (state_nxt == S_CLEAR) || (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
            paused    <= (state_nxt == S_PAUSE);
            done      <= (state_nxt == S_DONE);
        end
    end

`ifdef WATCHDOG_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err <= 1'b0;
        else       err <= (state_nxt == S_ERR);
    end
`else
    assign err = 1'b0;
`endif

endmodule
